lcd_pattern_gen: RTL

//  Pixel source that sits directly upstream of the LCD timing driver and produces its lcd_data.

---
 rtl/lcd_pattern_gen_pkg.sv | 107 ++++++++++
 rtl/lcd_pattern_gen_if.sv | 13 +
 rtl/lcd_pattern_gen_box_mover.sv | 41 ++++
 rtl/lcd_pattern_gen.sv | 115 +++++++++++
 4 files changed

// File: rtl/lcd_pattern_gen_pkg.sv
// Shared types and helpers for the LCD test-pattern source: mode encoding, bar colours,
// panel-ID resolution decode and the single-axis bounce step used by the box mover.
// No state, no latency, no backpressure: pure declarations and combinational functions.
package lcd_pkg;

   typedef enum logic [1:0] {
      MODE_BARS = 2'd0,
      MODE_GRID = 2'd1,
      MODE_BOX  = 2'd2,
      MODE_GRAD = 2'd3
   } mode_t;

   typedef logic [23:0] rgb_t;

   localparam rgb_t RGB_WHITE = 24'hFFFFFF;
   localparam rgb_t RGB_BLACK = 24'h000000;
   localparam rgb_t RGB_RED   = 24'hFF0000;

   // Panel geometry selected by lcd_id
   typedef struct packed {
      logic [10:0] h_disp;
      logic [10:0] v_disp;
      logic [10:0] bar_w;
   } res_t;

   // One axis of the bouncing box: position and direction (1 = right/down)
   typedef struct packed {
      logic [10:0] pos;
      logic        fwd;
   } axis_t;

   function automatic res_t lcd_res(input logic [15:0] id);
      res_t r;
      case (id)
         16'h4342, 16'h4384: r = '{h_disp: 11'd480,  v_disp: 11'd272, bar_w: 11'd60};
         16'h7084:           r = '{h_disp: 11'd800,  v_disp: 11'd480, bar_w: 11'd100};
         16'h7016:           r = '{h_disp: 11'd1024, v_disp: 11'd600, bar_w: 11'd128};
         default:            r = '{h_disp: 11'd1280, v_disp: 11'd800, bar_w: 11'd160};
      endcase
      return r;
   endfunction

   function automatic rgb_t bar_color(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      mode_t n;
      case (m)
         MODE_BARS: n = MODE_GRID;
         MODE_GRID: n = MODE_BOX;
         MODE_BOX:  n = MODE_GRAD;
         default:   n = MODE_BARS;
      endcase
      return n;
   endfunction

   // Travel limit for the box corner; a box wider than the panel pins at 0
   function automatic logic [10:0] box_limit(input logic [10:0] disp, input logic [10:0] size);
      return (disp > size) ? (disp - size) : 11'd0;
   endfunction

   // One frame of bounce on one axis. Compares are done at 12 bits so pos+step cannot wrap.
   function automatic axis_t box_axis_step(input axis_t cur, input logic [10:0] lim,
                                           input logic [10:0] step);
      axis_t       nxt;
      logic [11:0] pos_w;
      logic [11:0] lim_w;
      logic [11:0] step_w;
      pos_w  = {1'b0, cur.pos};
      lim_w  = {1'b0, lim};
      step_w = {1'b0, step};
      nxt    = cur;
      if (pos_w > lim_w) begin
         // Panel shrank under the box: snap to the new edge and head back
         nxt.pos = lim;
         nxt.fwd = 1'b0;
      end else if (cur.fwd) begin
         if (pos_w + step_w >= lim_w) begin
            nxt.pos = lim;
            nxt.fwd = 1'b0;
         end else begin
            nxt.pos = cur.pos + step;
         end
      end else begin
         if (pos_w <= step_w) begin
            nxt.pos = 11'd0;
            nxt.fwd = 1'b1;
         end else begin
            nxt.pos = cur.pos - step;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel link between the LCD timing driver (master) and the pattern source (slave).
// Latency: lcd_data answers data_req one cycle later. No backpressure: every request is served.
// Signals: lcd_id panel ID, lcd_xpos/lcd_ypos raw counters, data_req pixel request, lcd_data RGB888.
interface lcd_pattern_gen_if;
   logic [15:0] lcd_id;
   logic [10:0] lcd_xpos;
   logic [10:0] lcd_ypos;
   logic        data_req;
   logic [23:0] lcd_data;

   modport master (output lcd_id, lcd_xpos, lcd_ypos, data_req, input lcd_data);
   modport slave  (input lcd_id, lcd_xpos, lcd_ypos, data_req, output lcd_data);
endinterface

// File: rtl/lcd_pattern_gen_box_mover.sv
// Bouncing-box position: moves BOX_STEP per axis on every frame_start, reflects at the panel edges.
// Latency: new position visible the cycle after frame_start. No backpressure.
// Ports: clk, rst_n (async active-low), frame_start, h_disp/v_disp panel size, box_x/box_y corner.
module lcd_box_mover
   import lcd_pkg::*;
#(
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 4
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic [10:0] h_disp,
   input  logic [10:0] v_disp,
   output logic [10:0] box_x,
   output logic [10:0] box_y
);

   logic  dir_x;   // 1 = moving right
   logic  dir_y;   // 1 = moving down
   axis_t nxt_x;
   axis_t nxt_y;

   assign nxt_x = box_axis_step({box_x, dir_x}, box_limit(h_disp, 11'(BOX_SIZE)), 11'(BOX_STEP));
   assign nxt_y = box_axis_step({box_y, dir_y}, box_limit(v_disp, 11'(BOX_SIZE)), 11'(BOX_STEP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box_x <= 11'd0;
         box_y <= 11'd0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (frame_start) begin
         box_x <= nxt_x.pos;
         dir_x <= nxt_x.fwd;
         box_y <= nxt_y.pos;
         dir_y <= nxt_y.fwd;
      end
   end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source (bars/grid/bouncing box/gradient) feeding the LCD timing driver.
// Latency: one cycle from data_req to lcd_data. No backpressure: every request gets a pixel.
// Ports: clk_dri, sys_rst_n (async active-low), key_next pulse, disp_mode out, pix (slave link).
module lcd_pattern_gen
   import lcd_pkg::*;
#(
   parameter int FRAME_HOLD = 300,
   parameter int BOX_SIZE   = 64,
   parameter int BOX_STEP   = 4,
   parameter int GRID_SHIFT = 5
)(
   input  logic            clk_dri,
   input  logic            sys_rst_n,
   input  logic            key_next,
   output logic [1:0]      disp_mode,
   lcd_pattern_gen_if.slave pix
);

   localparam int             FCW     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_HOLD - 1);

   res_t           res;
   logic           frame_start;
   logic [10:0]    col;
   logic [10:0]    row;
   logic           req_d;
   mode_t          mode;
   logic [FCW-1:0] frame_cnt;
   logic           expire;
   logic [10:0]    box_x;
   logic [10:0]    box_y;
   rgb_t           pix_c;

   assign res         = lcd_res(pix.lcd_id);
   assign frame_start = (pix.lcd_xpos == 11'd0) && (pix.lcd_ypos == 11'd0);

   // Active-area coordinates: col counts within a request burst, row counts bursts since frame start
   always_ff @(posedge clk_dri or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         col   <= 11'd0;
         row   <= 11'd0;
         req_d <= 1'b0;
      end else begin
         req_d <= pix.data_req;
         col   <= pix.data_req ? (col + 11'd1) : 11'd0;
         if (frame_start)
            row <= 11'd0;
         else if (req_d && !pix.data_req)
            row <= row + 11'd1;
      end
   end

   // Key and frame expiry merge into a single advance, so a coincident pair steps once
   assign expire = frame_start && (frame_cnt == FC_LAST);

   always_ff @(posedge clk_dri or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode      <= MODE_BARS;
         frame_cnt <= '0;
      end else if (key_next || expire) begin
         mode      <= next_mode(mode);
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   assign disp_mode = mode;

   lcd_box_mover #(
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_box (
      .clk         (clk_dri),
      .rst_n       (sys_rst_n),
      .frame_start (frame_start),
      .h_disp      (res.h_disp),
      .v_disp      (res.v_disp),
      .box_x       (box_x),
      .box_y       (box_y)
   );

   always_comb begin
      logic [11:0] col_w;
      logic [11:0] row_w;
      logic [2:0]  bar_idx;
      logic        grid_hit;
      logic        box_hit;
      col_w   = {1'b0, col};
      row_w   = {1'b0, row};
      // Bar index = number of bar boundaries at or left of col; boundaries are k*bar_w
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (col_w >= 12'(k) * {1'b0, res.bar_w})
            bar_idx = 3'(k);
      end
      grid_hit = (col[GRID_SHIFT-1:0] == '0) || (row[GRID_SHIFT-1:0] == '0);
      box_hit  = (col_w >= {1'b0, box_x}) && (col_w < {1'b0, box_x} + 12'(BOX_SIZE)) &&
                 (row_w >= {1'b0, box_y}) && (row_w < {1'b0, box_y} + 12'(BOX_SIZE));
      case (mode)
         MODE_BARS: pix_c = bar_color(bar_idx);
         MODE_GRID: pix_c = grid_hit ? RGB_WHITE : RGB_BLACK;
         MODE_BOX:  pix_c = box_hit  ? RGB_RED   : RGB_BLACK;
         default:   pix_c = {col[7:0], col[7:0], col[7:0]};
      endcase
   end

   always_ff @(posedge clk_dri or negedge sys_rst_n) begin
      if (!sys_rst_n)
         pix.lcd_data <= 24'h0;
      else
         pix.lcd_data <= pix.data_req ? pix_c : 24'h0;
   end

endmodule
